multicycle_ctrl: RTL and testbench

//  Multicycle control FSM; the initiator side of the ALU interface. Decodes opcode/funct, drives

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/multicycle_ctrl_if.sv | 31 +++
 rtl/alu_decode.sv | 22 ++
 rtl/multicycle_ctrl.sv | 113 +++++++++++
 tb/tb_multicycle_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, opcode/funct encodings, aluop codes and datapath select constants.
package cpu_pkg;
   localparam int OPCODE_W = 6;
   localparam int FUNCT_W  = 6;
   localparam int ALUOP_W  = 4;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
      S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP
   } state_t;
   localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
   localparam logic [FUNCT_W-1:0] F_ADD  = 6'b100000;
   localparam logic [FUNCT_W-1:0] F_SUB  = 6'b100010;
   localparam logic [FUNCT_W-1:0] F_AND  = 6'b100100;
   localparam logic [FUNCT_W-1:0] F_OR   = 6'b100101;
   localparam logic [FUNCT_W-1:0] F_XOR  = 6'b100110;
   localparam logic [FUNCT_W-1:0] F_NOR  = 6'b100111;
   localparam logic [FUNCT_W-1:0] F_SLT  = 6'b101010;
   localparam logic [FUNCT_W-1:0] F_SLTU = 6'b101011;
   localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'b0000;
   localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'b0001;
   localparam logic [ALUOP_W-1:0] ALU_AND  = 4'b0100;
   localparam logic [ALUOP_W-1:0] ALU_OR   = 4'b0101;
   localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'b0110;
   localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'b0111;
   localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'b1000;
   localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'b1001;
   localparam logic       SRC_A_PC     = 1'b0;
   localparam logic       SRC_A_REG    = 1'b1;
   localparam logic [1:0] SRC_B_REG    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR   = 2'b01;
   localparam logic [1:0] SRC_B_IMM    = 2'b10;
   localparam logic [1:0] SRC_B_IMM_SH = 2'b11;
   localparam logic [1:0] PC_ALU       = 2'b00;
   localparam logic [1:0] PC_TGT       = 2'b01;
   localparam logic [1:0] PC_JUMP      = 2'b10;
   typedef struct packed {
      logic [ALUOP_W-1:0] aluop;
      logic               alu_src_a;
      logic [1:0]         alu_src_b;
      logic [1:0]         pc_src;
      logic               pc_write;
      logic               ir_write;
      logic               tgt_write;
      logic               iord;
      logic               mem_read;
      logic               mem_write;
      logic               reg_write;
      logic               reg_dst;
      logic               mem_to_reg;
      logic               illegal_op;
   } ctrl_t;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields and status in, control strobes and selects out.
interface multicycle_ctrl_if import cpu_pkg::*; ();
   logic [OPCODE_W-1:0] opcode;
   logic [FUNCT_W-1:0]  funct;
   logic                flag;
   logic                mem_ready;
   logic [ALUOP_W-1:0]  aluop;
   logic                alu_src_a;
   logic [1:0]          alu_src_b;
   logic [1:0]          pc_src;
   logic                pc_write;
   logic                ir_write;
   logic                tgt_write;
   logic                iord;
   logic                mem_read;
   logic                mem_write;
   logic                reg_write;
   logic                reg_dst;
   logic                mem_to_reg;
   logic                illegal_op;
   modport master (
      input  opcode, funct, flag, mem_ready,
      output aluop, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, tgt_write,
             iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op
   );
   modport slave (
      output opcode, funct, flag, mem_ready,
      input  aluop, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, tgt_write,
             iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op
   );
endinterface

// File: rtl/alu_decode.sv
// alu_decode: R-type funct to aluop; unknown funct flags illegal and falls back to ADD.
module alu_decode import cpu_pkg::*; (
   input  logic [FUNCT_W-1:0] funct,
   output logic [ALUOP_W-1:0] aluop,
   output logic               illegal
);
   always_comb begin
      aluop   = ALU_ADD;
      illegal = 1'b0;
      case (funct)
         F_ADD:   aluop = ALU_ADD;
         F_SUB:   aluop = ALU_SUB;
         F_AND:   aluop = ALU_AND;
         F_OR:    aluop = ALU_OR;
         F_XOR:   aluop = ALU_XOR;
         F_NOR:   aluop = ALU_NOR;
         F_SLT:   aluop = ALU_SLT;
         F_SLTU:  aluop = ALU_SLTU;
         default: illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle CPU control FSM; Moore outputs except mem_ready/flag-gated PC and IR loads.
module multicycle_ctrl import cpu_pkg::*; (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);
   state_t             state_q, state_d;
   ctrl_t              c, o;
   logic [ALUOP_W-1:0] r_aluop;
   logic               r_illegal;
   alu_decode u_alu_decode (.funct(bus.funct), .aluop(r_aluop), .illegal(r_illegal));
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end
   always_comb begin
      c       = '0;
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_FOUR;
            c.pc_src    = PC_ALU;
            c.ir_write  = bus.mem_ready;
            c.pc_write  = bus.mem_ready;
            state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            c.alu_src_a = SRC_A_PC;
            c.alu_src_b = SRC_B_IMM_SH;
            c.tgt_write = 1'b1;
            case (bus.opcode)
               OP_RTYPE:     state_d = S_EXEC_R;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_ADDI:      state_d = S_EXEC_I;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
                  c.illegal_op = 1'b1;
                  state_d      = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            c.alu_src_a  = SRC_A_REG;
            c.alu_src_b  = SRC_B_REG;
            c.aluop      = r_aluop;
            c.illegal_op = r_illegal;
            state_d      = r_illegal ? S_FETCH : S_WB_R;
         end
         S_WB_R: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
            state_d     = S_FETCH;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            c.alu_src_a = SRC_A_REG;
            c.alu_src_b = SRC_B_IMM;
            state_d     = state_q == S_EXEC_I ? S_WB_I : bus.opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
         end
         S_WB_I: begin
            c.reg_write = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_RD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
            state_d    = bus.mem_ready ? S_WB_MEM : S_MEM_RD;
         end
         S_WB_MEM: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WR: begin
            c.mem_write = 1'b1;
            c.iord      = 1'b1;
            state_d     = bus.mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_BRANCH: begin
            c.alu_src_a = SRC_A_REG;
            c.alu_src_b = SRC_B_REG;
            c.aluop     = ALU_SUB;
            c.pc_src    = PC_TGT;
            c.pc_write  = bus.opcode == OP_BNE ? !bus.flag : bus.flag;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            c.pc_src   = PC_JUMP;
            c.pc_write = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end
   // Reset kills every request/strobe in the same cycle, even mid memory wait.
   assign o              = reset ? '0 : c;
   assign bus.aluop      = o.aluop;
   assign bus.alu_src_a  = o.alu_src_a;
   assign bus.alu_src_b  = o.alu_src_b;
   assign bus.pc_src     = o.pc_src;
   assign bus.pc_write   = o.pc_write;
   assign bus.ir_write   = o.ir_write;
   assign bus.tgt_write  = o.tgt_write;
   assign bus.iord       = o.iord;
   assign bus.mem_read   = o.mem_read;
   assign bus.mem_write  = o.mem_write;
   assign bus.reg_write  = o.reg_write;
   assign bus.reg_dst    = o.reg_dst;
   assign bus.mem_to_reg = o.mem_to_reg;
   assign bus.illegal_op = o.illegal_op;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors; expected outputs queued by stimulus, checked by a negedge monitor.
module tb_multicycle_ctrl;
   import cpu_pkg::*;
   typedef struct {
      string name;
      ctrl_t exp;
   } item_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   item_t sb[$];
   multicycle_ctrl_if bus ();
   multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   function automatic ctrl_t e_fetch(logic r);
      ctrl_t e = '0;
      e.mem_read  = 1'b1;
      e.alu_src_b = 2'b01;
      e.ir_write  = r;
      e.pc_write  = r;
      return e;
   endfunction
   function automatic ctrl_t e_decode(logic ill);
      ctrl_t e = '0;
      e.alu_src_b  = 2'b11;
      e.tgt_write  = 1'b1;
      e.illegal_op = ill;
      return e;
   endfunction
   function automatic ctrl_t e_exec_r(logic [3:0] op, logic ill);
      ctrl_t e = '0;
      e.alu_src_a  = 1'b1;
      e.aluop      = op;
      e.illegal_op = ill;
      return e;
   endfunction
   function automatic ctrl_t e_imm();
      ctrl_t e = '0;
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b10;
      return e;
   endfunction
   function automatic ctrl_t e_wb(logic dst, logic m2r);
      ctrl_t e = '0;
      e.reg_write  = 1'b1;
      e.reg_dst    = dst;
      e.mem_to_reg = m2r;
      return e;
   endfunction
   function automatic ctrl_t e_mem(logic wr);
      ctrl_t e = '0;
      e.iord      = 1'b1;
      e.mem_read  = !wr;
      e.mem_write = wr;
      return e;
   endfunction
   function automatic ctrl_t e_branch(logic pw);
      ctrl_t e = '0;
      e.alu_src_a = 1'b1;
      e.aluop     = 4'b0001;
      e.pc_src    = 2'b01;
      e.pc_write  = pw;
      return e;
   endfunction
   function automatic ctrl_t e_jump();
      ctrl_t e = '0;
      e.pc_src   = 2'b10;
      e.pc_write = 1'b1;
      return e;
   endfunction
   task automatic step(string name, logic rst, logic [5:0] op, logic [5:0] fn, logic fl, logic rdy, ctrl_t exp);
      @(posedge clk);
      #1;
      reset         = rst;
      bus.opcode    = op;
      bus.funct     = fn;
      bus.flag      = fl;
      bus.mem_ready = rdy;
      sb.push_back('{name, exp});
   endtask
   task automatic r_type(string name, logic [5:0] fn, logic [3:0] op);
      step({name, "_fetch"}, 0, 6'b000000, fn, 0, 1, e_fetch(1));
      step({name, "_decode"}, 0, 6'b000000, fn, 0, 1, e_decode(0));
      step({name, "_exec"}, 0, 6'b000000, fn, 0, 1, e_exec_r(op, 0));
      step({name, "_wb"}, 0, 6'b000000, fn, 0, 1, e_wb(1, 0));
   endtask
   task automatic branch(string name, logic [5:0] op, logic fl, logic pw);
      step({name, "_fetch"}, 0, op, 6'b0, fl, 1, e_fetch(1));
      step({name, "_decode"}, 0, op, 6'b0, fl, 1, e_decode(0));
      step({name, "_branch"}, 0, op, 6'b0, fl, 1, e_branch(pw));
   endtask
   always @(negedge clk) begin
      ctrl_t act;
      item_t it;
      if (sb.size() > 0) begin
         it = sb.pop_front();
         act.aluop      = bus.aluop;
         act.alu_src_a  = bus.alu_src_a;
         act.alu_src_b  = bus.alu_src_b;
         act.pc_src     = bus.pc_src;
         act.pc_write   = bus.pc_write;
         act.ir_write   = bus.ir_write;
         act.tgt_write  = bus.tgt_write;
         act.iord       = bus.iord;
         act.mem_read   = bus.mem_read;
         act.mem_write  = bus.mem_write;
         act.reg_write  = bus.reg_write;
         act.reg_dst    = bus.reg_dst;
         act.mem_to_reg = bus.mem_to_reg;
         act.illegal_op = bus.illegal_op;
         checks++;
         if (act !== it.exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b (aluop,src_a,src_b,pc_src,pc_w,ir_w,tgt_w,iord,mrd,mwr,rw,dst,m2r,ill)", it.name, act, it.exp);
         end
      end
   end
   initial begin
      bus.opcode = '0; bus.funct = '0; bus.flag = 1'b0; bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("reset", 1, 6'b000000, 6'b0, 0, 0, ctrl_t'('0));
      step("fetch_wait0", 0, 6'b000000, 6'b100010, 0, 0, e_fetch(0));
      step("fetch_wait1", 0, 6'b000000, 6'b100010, 0, 0, e_fetch(0));
      r_type("sub", 6'b100010, 4'b0001);
      r_type("add", 6'b100000, 4'b0000);
      r_type("and", 6'b100100, 4'b0100);
      r_type("or", 6'b100101, 4'b0101);
      r_type("xor", 6'b100110, 4'b0110);
      r_type("nor", 6'b100111, 4'b0111);
      r_type("slt", 6'b101010, 4'b1000);
      r_type("sltu", 6'b101011, 4'b1001);
      step("badfn_fetch", 0, 6'b000000, 6'b000000, 0, 1, e_fetch(1));
      step("badfn_decode", 0, 6'b000000, 6'b000000, 0, 1, e_decode(0));
      step("badfn_exec", 0, 6'b000000, 6'b000000, 0, 1, e_exec_r(4'b0000, 1));
      step("badfn_refetch", 0, 6'b000000, 6'b000000, 0, 0, e_fetch(0));
      step("lw_fetch", 0, 6'b100011, 6'b0, 0, 1, e_fetch(1));
      step("lw_decode", 0, 6'b100011, 6'b0, 0, 1, e_decode(0));
      step("lw_addr", 0, 6'b100011, 6'b0, 0, 0, e_imm());
      step("lw_rd_wait0", 0, 6'b100011, 6'b0, 0, 0, e_mem(0));
      step("lw_rd_wait1", 0, 6'b100011, 6'b0, 0, 0, e_mem(0));
      step("lw_rd_done", 0, 6'b100011, 6'b0, 0, 1, e_mem(0));
      step("lw_wb", 0, 6'b100011, 6'b0, 0, 1, e_wb(0, 1));
      step("addi_fetch", 0, 6'b001000, 6'b0, 0, 1, e_fetch(1));
      step("addi_decode", 0, 6'b001000, 6'b0, 0, 1, e_decode(0));
      step("addi_exec", 0, 6'b001000, 6'b0, 0, 1, e_imm());
      step("addi_wb", 0, 6'b001000, 6'b0, 0, 1, e_wb(0, 0));
      branch("beq_taken", 6'b000100, 1, 1);
      branch("beq_not", 6'b000100, 0, 0);
      branch("bne_not", 6'b000101, 1, 0);
      branch("bne_taken", 6'b000101, 0, 1);
      step("j_fetch", 0, 6'b000010, 6'b0, 0, 1, e_fetch(1));
      step("j_decode", 0, 6'b000010, 6'b0, 0, 1, e_decode(0));
      step("j_jump", 0, 6'b000010, 6'b0, 0, 1, e_jump());
      step("ill_fetch", 0, 6'b111111, 6'b0, 0, 1, e_fetch(1));
      step("ill_decode", 0, 6'b111111, 6'b0, 0, 1, e_decode(1));
      step("ill_refetch", 0, 6'b111111, 6'b0, 0, 0, e_fetch(0));
      step("sw_fetch", 0, 6'b101011, 6'b0, 0, 1, e_fetch(1));
      step("sw_decode", 0, 6'b101011, 6'b0, 0, 1, e_decode(0));
      step("sw_addr", 0, 6'b101011, 6'b0, 0, 0, e_imm());
      step("sw_wait", 0, 6'b101011, 6'b0, 0, 0, e_mem(1));
      step("sw_reset", 1, 6'b101011, 6'b0, 0, 0, ctrl_t'('0));
      step("sw_after_reset", 0, 6'b101011, 6'b0, 0, 0, e_fetch(0));
      step("fetch_reset", 1, 6'b000000, 6'b0, 0, 1, ctrl_t'('0));
      step("fetch_after_reset", 0, 6'b000000, 6'b0, 0, 1, e_fetch(1));
      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
